// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N:1 datapath multiplexer feeding a registered valid/ready
// output stage. The channel is picked either by an external select (MODE=0)
// or by an internal round-robin arbiter (MODE=1).
module arb_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int MODE  = 0,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] ch_data [N_IN];
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [SEL_W-1:0] rr_cand;
  logic             rr_found;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic [WIDTH-1:0] cand_data;
  logic             load;
  logic             xfer;

  // The output register can take a word when it is empty or being drained.
  assign load = ~out_valid | out_ready;

  // Unpack the flattened input bus and drive one ready bit per channel;
  // only the current candidate can ever see ready, so ready stays one-hot.
  for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
    assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi] = load & cand_ok & (cand == SEL_W'(gi));
  end

  // Round-robin scan: first valid channel starting at ptr, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!rr_found && in_valid[SEL_W'(idx)]) begin
        rr_found = 1'b1;
        rr_cand  = SEL_W'(idx);
      end
    end
  end

  // Pick the candidate for the active mode; an out-of-range select means
  // no channel is offered at all.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (MODE == 1) begin
      cand    = rr_cand;
      cand_ok = rr_found;
    end else begin
      cand    = sel;
      cand_ok = (int'(sel) < N_IN);
    end
  end

  // Data of the candidate channel, zero when the candidate does not exist.
  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (cand == SEL_W'(i)) cand_data = ch_data[SEL_W'(i)];
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign ptr_next = (cand == SEL_W'(N_IN - 1)) ? '0 : cand + SEL_W'(1);

  // Output register and arbitration pointer: fill on transfer (replacing a
  // word being drained in the same edge), empty on a drain with no refill,
  // otherwise hold; the pointer only moves past a granted channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_src   <= cand;
        if (MODE == 1) ptr <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: directed checks of arb_mux_reg in three configurations:
// external select with 4 inputs, round-robin with 4 inputs, and external
// select with 3 inputs (exercising an out-of-range select).
module tb_arb_mux_reg;

  logic clk;
  logic rst;

  logic [3:0]   v0;
  logic [127:0] d0;
  logic [3:0]   r0;
  logic [1:0]   s0;
  logic         ov0;
  logic [31:0]  od0;
  logic [1:0]   os0;
  logic         ord0;

  logic [3:0]   v1;
  logic [127:0] d1;
  logic [3:0]   r1;
  logic [1:0]   s1;
  logic         ov1;
  logic [31:0]  od1;
  logic [1:0]   os1;
  logic         ord1;

  logic [2:0]   v2;
  logic [95:0]  d2;
  logic [2:0]   r2;
  logic [1:0]   s2;
  logic         ov2;
  logic [31:0]  od2;
  logic [1:0]   os2;
  logic         ord2;

  int compared;
  int mismatched;
  logic [31:0] ch [4];

  arb_mux_reg #(.WIDTH(32), .N_IN(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .sel(s0), .out_valid(ov0), .out_data(od0), .out_src(os0), .out_ready(ord0)
  );

  arb_mux_reg #(.WIDTH(32), .N_IN(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .sel(s1), .out_valid(ov1), .out_data(od1), .out_src(os1), .out_ready(ord1)
  );

  arb_mux_reg #(.WIDTH(32), .N_IN(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(r2),
    .sel(s2), .out_valid(ov2), .out_data(od2), .out_src(os2), .out_ready(ord2)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    v0 = '0; d0 = '0; s0 = '0; ord0 = 1'b0;
    v1 = '0; d1 = '0; s1 = '0; ord1 = 1'b0;
    v2 = '0; d2 = '0; s2 = '0; ord2 = 1'b0;

    #2;
    checkOutput("reset_valid", 64'(ov0), 64'(1'b0));
    checkOutput("reset_data", 64'(od0), 64'(32'h0));
    checkOutput("reset_src", 64'(os0), 64'(2'd0));
    #10;
    rst = 1'b0;

    // Reset while stalled with a word held in the output register.
    v0 = 4'b0100; d0[64 +: 32] = 32'hDEADBEEF; s0 = 2'd2; ord0 = 1'b0;
    #1;
    checkOutput("load_ready_ch2", 64'(r0), 64'(4'b0100));
    applyStimulus();
    checkOutput("load_valid", 64'(ov0), 64'(1'b1));
    checkOutput("load_data", 64'(od0), 64'(32'hDEADBEEF));
    checkOutput("load_src", 64'(os0), 64'(2'd2));
    v0 = 4'b0000;
    #1;
    checkOutput("stall_ready", 64'(r0), 64'(4'b0000));
    applyStimulus();
    checkOutput("stall_hold_data", 64'(od0), 64'(32'hDEADBEEF));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 64'(ov0), 64'(1'b0));
    checkOutput("async_rst_data", 64'(od0), 64'(32'h0));
    checkOutput("async_rst_src", 64'(os0), 64'(2'd0));
    rst = 1'b0;
    applyStimulus();
    checkOutput("post_rst_no_word", 64'(ov0), 64'(1'b0));

    // External select sweep over all four channels.
    for (int i = 0; i < 4; i++) ch[i] = $urandom;
    d0 = {ch[3], ch[2], ch[1], ch[0]};
    v0 = 4'hF; ord0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = 2'(i);
      #1;
      checkOutput("sweep_ready", 64'(r0), 64'(4'b0001 << i));
      applyStimulus();
      checkOutput("sweep_valid", 64'(ov0), 64'(1'b1));
      checkOutput("sweep_data", 64'(od0), 64'(ch[i]));
      checkOutput("sweep_src", 64'(os0), 64'(i));
    end
    v0 = 4'h0;
    applyStimulus();
    checkOutput("sweep_drain", 64'(ov0), 64'(1'b0));

    // Backpressure: first word must stay put until the sink is ready.
    s0 = 2'd1; v0 = 4'b0010; d0[32 +: 32] = 32'h12345678; ord0 = 1'b0;
    #1;
    checkOutput("bp_ready_idle", 64'(r0), 64'(4'b0010));
    applyStimulus();
    checkOutput("bp_first_data", 64'(od0), 64'(32'h12345678));
    d0[32 +: 32] = 32'h9ABCDEF0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("bp_ready_stall", 64'(r0), 64'(4'b0000));
      applyStimulus();
      checkOutput("bp_hold_valid", 64'(ov0), 64'(1'b1));
      checkOutput("bp_hold_data", 64'(od0), 64'(32'h12345678));
    end
    ord0 = 1'b1;
    #1;
    checkOutput("bp_ready_release", 64'(r0), 64'(4'b0010));
    applyStimulus();
    checkOutput("bp_second_valid", 64'(ov0), 64'(1'b1));
    checkOutput("bp_second_data", 64'(od0), 64'(32'h9ABCDEF0));
    v0 = 4'h0;
    applyStimulus();
    checkOutput("bp_drain", 64'(ov0), 64'(1'b0));

    // Round-robin fairness with every channel requesting.
    d1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    v1 = 4'hF; ord1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("rr_ready", 64'(r1), 64'(4'b0001 << (k % 4)));
      applyStimulus();
      checkOutput("rr_src", 64'(os1), 64'(k % 4));
      checkOutput("rr_data", 64'(od1), 64'(32'hA0 + (k % 4)));
      checkOutput("rr_valid", 64'(ov1), 64'(1'b1));
    end
    v1 = 4'h0;
    applyStimulus();
    checkOutput("rr_drain", 64'(ov1), 64'(1'b0));

    // Skip and wrap: pointer at 1 after a ch0 grant, requests on ch0/ch3.
    v1 = 4'b0001;
    #1;
    checkOutput("skip_ready_ch0", 64'(r1), 64'(4'b0001));
    applyStimulus();
    checkOutput("skip_src_ch0", 64'(os1), 64'(2'd0));
    v1 = 4'b1001;
    #1;
    checkOutput("skip_ready_ch3", 64'(r1), 64'(4'b1000));
    applyStimulus();
    checkOutput("skip_src_ch3", 64'(os1), 64'(2'd3));
    checkOutput("skip_data_ch3", 64'(od1), 64'(32'hA3));
    checkOutput("wrap_ready_ch0", 64'(r1), 64'(4'b0001));
    applyStimulus();
    checkOutput("wrap_src_ch0", 64'(os1), 64'(2'd0));
    checkOutput("wrap_ready_ch3", 64'(r1), 64'(4'b1000));

    // No requests: output empties and the pointer stays at 1.
    v1 = 4'b0000;
    applyStimulus();
    checkOutput("noreq_valid", 64'(ov1), 64'(1'b0));
    applyStimulus();
    checkOutput("noreq_valid_hold", 64'(ov1), 64'(1'b0));
    checkOutput("noreq_ready", 64'(r1), 64'(4'b0000));
    v1 = 4'hF;
    #1;
    checkOutput("noreq_ptr_kept", 64'(r1), 64'(4'b0010));
    v1 = 4'h0;

    // Three inputs with external select, including the unused select code.
    d2 = {32'h33, 32'h22, 32'h11};
    v2 = 3'b111; s2 = 2'd0; ord2 = 1'b1;
    #1;
    checkOutput("n3_ready_ch0", 64'(r2), 64'(3'b001));
    applyStimulus();
    checkOutput("n3_data_ch0", 64'(od2), 64'(32'h11));
    checkOutput("n3_valid_ch0", 64'(ov2), 64'(1'b1));
    s2 = 2'd3;
    #1;
    checkOutput("n3_ready_bad_sel", 64'(r2), 64'(3'b000));
    applyStimulus();
    checkOutput("n3_bad_sel_drain", 64'(ov2), 64'(1'b0));
    s2 = 2'd2;
    #1;
    checkOutput("n3_ready_ch2", 64'(r2), 64'(3'b100));
    applyStimulus();
    checkOutput("n3_data_ch2", 64'(od2), 64'(32'h33));
    checkOutput("n3_src_ch2", 64'(os2), 64'(2'd2));
    v2 = 3'b000;
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
